// File: rtl/mil_std_xmt_encoder_if.sv
// Control/status and line-side signals of the MIL-STD-1553 transmit encoder.
// The CSR block is the master; the encoder itself is the slave.
interface mil_std_xmt_encoder_if;
   logic        enable_i;
   logic        send_i;
   logic [15:0] data_i;
   logic        sync_c_i;
   logic        busy_o;
   logic        done_o;
   logic        tx_p_o;
   logic        tx_n_o;
   logic        tx_en_o;

   modport master (
      output enable_i, send_i, data_i, sync_c_i,
      input  busy_o, done_o, tx_p_o, tx_n_o, tx_en_o
   );

   modport slave (
      input  enable_i, send_i, data_i, sync_c_i,
      output busy_o, done_o, tx_p_o, tx_n_o, tx_en_o
   );
endinterface

// File: rtl/mil_std_xmt_encoder.sv
// MIL-STD-1553 transmit encoder: one 16-bit word as a 40 half-bit Manchester II frame
// (3-bit sync, 16 data bits MSB first, odd parity) on a registered differential pair.
module mil_std_xmt_encoder #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BIT_RATE_HZ = 1_000_000
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   mil_std_xmt_encoder_if.slave  bus
);
   localparam int HALF_BIT_CYCLES = CLK_FREQ_HZ / (2 * BIT_RATE_HZ);
   localparam int CNT_W = (HALF_BIT_CYCLES > 2) ? $clog2(HALF_BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HALF_BIT_CYCLES - 1);
   localparam logic [5:0] LAST_SYNC   = 6'd5;
   localparam logic [5:0] LAST_DATA   = 6'd37;
   localparam logic [5:0] LAST_PARITY = 6'd39;

   generate
      if (HALF_BIT_CYCLES < 2) begin : g_bad_rate
         $error("mil_std_xmt_encoder: HALF_BIT_CYCLES must be at least 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_DATA,
      ST_PARITY,
      ST_DONE
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] half_cnt;
   logic [5:0]       half_idx;
   logic [15:0]      shreg;
   logic             sync_c_q;
   logic             parity_q;

   logic             busy_q;
   logic             done_q;
   logic             tx_p_q;
   logic             tx_n_q;
   logic             tx_en_q;

   logic             busy_next;
   logic             done_next;
   logic             tx_p_next;
   logic             tx_en_next;

   logic             start;
   logic             active;
   logic             half_end;

   assign start    = (state == ST_IDLE) && bus.send_i && bus.enable_i;
   assign active   = (state == ST_SYNC) || (state == ST_DATA) || (state == ST_PARITY);
   assign half_end = (half_cnt == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Line level for the half-bit currently being timed; it reaches the pins one edge later.
   always_comb begin
      state_next = state;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      tx_p_next  = 1'b0;
      tx_en_next = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_next = ST_SYNC;
            end
         end
         ST_SYNC: begin
            busy_next  = 1'b1;
            tx_en_next = 1'b1;
            tx_p_next  = sync_c_q ? (half_idx < 6'd3) : (half_idx >= 6'd3);
            if (half_end && (half_idx == LAST_SYNC)) begin
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            busy_next  = 1'b1;
            tx_en_next = 1'b1;
            tx_p_next  = shreg[15] ^ half_idx[0];
            if (half_end && (half_idx == LAST_DATA)) begin
               state_next = ST_PARITY;
            end
         end
         ST_PARITY: begin
            busy_next  = 1'b1;
            tx_en_next = 1'b1;
            tx_p_next  = parity_q ^ half_idx[0];
            if (half_end && (half_idx == LAST_PARITY)) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (active && !bus.enable_i) begin
         state_next = ST_IDLE;
         busy_next  = 1'b0;
         tx_en_next = 1'b0;
         tx_p_next  = 1'b0;
      end
   end

   // Even half-bit indices are the first half of a bit, so the shift happens after odd ones.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         half_cnt <= '0;
         half_idx <= '0;
         shreg    <= '0;
         sync_c_q <= 1'b0;
         parity_q <= 1'b0;
      end else if (start) begin
         half_cnt <= CNT_LOAD;
         half_idx <= '0;
         shreg    <= bus.data_i;
         sync_c_q <= bus.sync_c_i;
         parity_q <= ~^bus.data_i;
      end else if (active && bus.enable_i) begin
         if (half_end) begin
            half_cnt <= CNT_LOAD;
            half_idx <= half_idx + 6'd1;
            if ((state == ST_DATA) && half_idx[0]) begin
               shreg <= {shreg[14:0], 1'b0};
            end
         end else begin
            half_cnt <= half_cnt - 1'b1;
         end
      end else begin
         half_cnt <= '0;
         half_idx <= '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tx_p_q  <= 1'b0;
         tx_n_q  <= 1'b0;
         tx_en_q <= 1'b0;
      end else begin
         busy_q  <= busy_next;
         done_q  <= done_next;
         tx_p_q  <= tx_p_next;
         tx_n_q  <= tx_en_next & ~tx_p_next;
         tx_en_q <= tx_en_next;
      end
   end

   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;
   assign bus.tx_p_o  = tx_p_q;
   assign bus.tx_n_o  = tx_n_q;
   assign bus.tx_en_o = tx_en_q;
endmodule
